// File: rtl/addsub_serial_pkg.sv
// rtl/addsub_serial_pkg.sv - shared FSM encodings and sizing helper for addsub_serial
// Purpose : state encodings for the digit-serial adder FSM and a clog2 helper
//           used to size the digit counter.
// Ports   : none (package).
package addsub_serial_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Returns at least 1 so a single-digit configuration still gets a
    // one-bit counter instead of a zero-width vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - combinational DIGIT-bit add/subtract ripple slice
// Purpose : one digit of the serial adder; B is inverted when sel=1 and the
//           caller supplies the carry (initialised to sel for subtract).
// Ports   : a, b      digit operands
//           cin       carry into bit 0
//           sel       0 = add, 1 = subtract
//           sum       digit result
//           co        carry out of the top bit
//           c_msb_in  carry into the top bit (for signed overflow)
module addsub_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic             sel,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] bx;

    always_comb begin
        bx   = b ^ {DIGIT{sel}};
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ bx[i] ^ c[i];
            c[i + 1] = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
        end
    end

    assign co       = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial two's-complement adder/subtractor
// Purpose : computes A+B or A-B over WIDTH/DIGIT clocks under a start/done
//           handshake and registers carry, signed overflow and zero flags.
// Ports   : clk, rst          clock, synchronous active-high reset
//           start             request, honoured in IDLE or DONE
//           A, B, sel         operands and op (0 add, 1 subtract)
//           busy              digits in progress
//           done              one-cycle result-valid pulse
//           sum, co, ovf, zero result and flags
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic             carry;
    logic             sel_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    int               base;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] d_sum;
    logic             d_co;
    logic             d_cmsb;
    logic [WIDTH-1:0] sum_next;

    // Digit mux: k selects which slice of the latched operands feeds the slice.
    always_comb begin
        base  = int'(k) * DIGIT;
        a_dig = a_q[base +: DIGIT];
        b_dig = b_q[base +: DIGIT];
    end

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a        (a_dig),
        .b        (b_dig),
        .cin      (carry),
        .sel      (sel_q),
        .sum      (d_sum),
        .co       (d_co),
        .c_msb_in (d_cmsb)
    );

    // Sum as it will look after this step; zero is judged on the full result.
    always_comb begin
        sum_next = sum;
        sum_next[base +: DIGIT] = d_sum;
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            k     <= '0;
            carry <= 1'b0;
            sel_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        sel_q <= sel;
                        carry <= sel;   // +1 of the two's-complement negate
                        k     <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum   <= sum_next;
                    carry <= d_co;
                    if (k == K_LAST) begin
                        co    <= d_co;
                        ovf   <= d_co ^ d_cmsb;
                        zero  <= (sum_next == '0);
                        k     <= '0;
                        state <= ST_DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - self-checking bench for addsub_serial (32/8 and 8/1)
module tb_addsub_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start32 = 1'b0, sel32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, co32, ovf32, zero32;
    logic [31:0] sum32;

    logic        start8 = 1'b0, sel8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, co8, ovf8, zero8;
    logic [7:0]  sum8;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(32), .DIGIT(8)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32), .sel(sel32),
        .busy(busy32), .done(done32), .sum(sum32), .co(co32), .ovf(ovf32), .zero(zero32)
    );

    addsub_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .sel(sel8),
        .busy(busy8), .done(done8), .sum(sum8), .co(co8), .ovf(ovf8), .zero(zero8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    // Returns {zero, ovf, co, sum}.
    function automatic logic [34:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
        longint modv, ua, ub, r, rm, sa, sb, st;
        logic   c, v, z;
        modv = longint'(1) << w;
        ua   = longint'(a) & (modv - 1);
        ub   = longint'(b) & (modv - 1);
        r    = s ? (ua - ub) : (ua + ub);
        c    = s ? (ua >= ub) : (r >= modv);
        rm   = ((r % modv) + modv) % modv;
        sa   = (ua >= modv / 2) ? ua - modv : ua;
        sb   = (ub >= modv / 2) ? ub - modv : ub;
        st   = s ? (sa - sb) : (sa + sb);
        v    = (st < -(modv / 2)) || (st >= modv / 2);
        z    = (rm == 0);
        return {z, v, c, rm[31:0]};
    endfunction

    task automatic drive(input int w, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
        if (w == 32) begin
            start32 = st; a32 = a; b32 = b; sel32 = s;
        end else begin
            start8 = st; a8 = a[7:0]; b8 = b[7:0]; sel8 = s;
        end
    endtask

    function automatic logic obs_done(input int w);
        return (w == 32) ? done32 : done8;
    endfunction

    function automatic logic obs_busy(input int w);
        return (w == 32) ? busy32 : busy8;
    endfunction

    function automatic logic [34:0] obs_res(input int w);
        return (w == 32) ? {zero32, ovf32, co32, sum32} : {zero8, ovf8, co8, 24'd0, sum8};
    endfunction

    // Called just after the negedge where start was driven high. Deasserts
    // start with garbage operands each cycle; optionally pulses start in RUN.
    task automatic wait_done(input int w, input bit poke, output int lat);
        lat = 0;
        do begin
            if (poke && lat == 2)
                drive(w, 1'b1, $urandom, $urandom, 1'($urandom));
            else
                drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
            @(negedge clk);
            lat++;
            if (lat == 1) check("busy_after_start", 32'(obs_busy(w)), 32'd1);
        end while (!obs_done(w) && lat < 40);
    endtask

    task automatic check_result(input string tag, input int w, input logic [34:0] exp);
        logic [34:0] got;
        got = obs_res(w);
        check({tag, "_sum"},  got[31:0], exp[31:0]);
        check({tag, "_co"},   32'(got[32]), 32'(exp[32]));
        check({tag, "_ovf"},  32'(got[33]), 32'(exp[33]));
        check({tag, "_zero"}, 32'(got[34]), 32'(exp[34]));
    endtask

    task automatic run_op(input string tag, input int w, input logic [31:0] a,
                          input logic [31:0] b, input logic s, input bit poke);
        int lat;
        drive(w, 1'b1, a, b, s);
        @(negedge clk);
        wait_done(w, poke, lat);
        check({tag, "_latency"}, 32'(lat), (w == 32) ? 32'd4 : 32'd8);
        check({tag, "_busy_at_done"}, 32'(obs_busy(w)), 32'd0);
        check_result(tag, w, model(w, a, b, s));
        drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(obs_done(w)), 32'd0);
        check_result({tag, "_hold"}, w, model(w, a, b, s));
    endtask

    initial begin
        int lat;
        int stray;
        logic [31:0] ra, rb;
        logic        rs;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy32", 32'(busy32), 32'd0);
        check("rst_done32", 32'(done32), 32'd0);
        check_result("rst32", 32, 35'd0);
        check_result("rst8", 8, 35'd0);
        @(negedge clk);

        run_op("add_wrap",  32, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("sub_neg",   32, 32'd5,         32'd7,         1'b1, 1'b0);
        run_op("sub_ovf",   32, 32'h8000_0000, 32'd1,         1'b1, 1'b0);
        run_op("add_ovf",   32, 32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0);
        run_op("run_start", 32, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1);
        run_op("w8_min",     8, 32'h80,        32'h80,        1'b0, 1'b0);
        run_op("w8_poke",    8, 32'h7F,        32'hFF,        1'b1, 1'b1);

        // Back-to-back: start held in DONE launches the next op immediately.
        drive(32, 1'b1, 32'd10, 32'd20, 1'b0);
        @(negedge clk);
        wait_done(32, 1'b0, lat);
        check("b2b_first_sum", sum32, 32'd30);
        drive(32, 1'b1, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        wait_done(32, 1'b0, lat);
        check("b2b_spacing", 32'(lat), 32'd4);
        check_result("b2b_second", 32, model(32, 32'd3, 32'd4, 1'b0));
        drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);

        // Reset during the second RUN cycle abandons the operation.
        run_op("pre_rst", 32, 32'hFFFF_0000, 32'h0000_1234, 1'b0, 1'b0);
        drive(32, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        @(negedge clk);
        drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy32), 32'd0);
        check("midrst_done", 32'(done32), 32'd0);
        check_result("midrst", 32, 35'd0);
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (done32 || busy32) stray++;
        end
        check("midrst_no_done", 32'(stray), 32'd0);

        // Random sweep over both configurations.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            if (i % 6 == 0) rb = ra;
            run_op("rand32", 32, ra, rb, rs, 1'($urandom));
            run_op("rand8",   8, ra, rb, rs, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
